// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU (optional macro: DIV_EARLY_OUT_EN)
module alu_div_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_kill,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [4:0]            i_req_op,
   input  logic [DATA_WIDTH-1:0] i_req_a,
   input  logic [DATA_WIDTH-1:0] i_req_b,
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [DATA_WIDTH-1:0] o_resp_result,
   output logic                  o_busy
);

   localparam logic [4:0] ALU_DIV  = 5'd16;
   localparam logic [4:0] ALU_DIVU = 5'd17;
   localparam logic [4:0] ALU_REM  = 5'd18;
   localparam logic [4:0] ALU_REMU = 5'd19;

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [4:0]            r_op;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_dvd;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_result;

   function automatic logic [DATA_WIDTH-1:0] f_abs(input logic [DATA_WIDTH-1:0] v, input logic s);
      return (s && v[DATA_WIDTH-1]) ? -v : v;
   endfunction

   // request-side decode: the dividend magnitude is loaded into the shift register at accept
   logic                  w_accept;
   logic                  w_in_signed;
   logic [DATA_WIDTH-1:0] w_in_abs_a;

   assign w_accept    = (r_state == IDLE) && i_req_valid && !i_kill;
   assign w_in_signed = (i_req_op == ALU_DIV) || (i_req_op == ALU_REM);
   assign w_in_abs_a  = f_abs(i_req_a, w_in_signed);

   // latched-operand decode, stable for the whole operation
   logic                  w_signed;
   logic                  w_is_rem;
   logic                  w_valid_op;
   logic                  w_b_zero;
   logic                  w_ovf;
   logic                  w_early;
   logic                  w_special;
   logic [DATA_WIDTH-1:0] w_special_res;
   logic [DATA_WIDTH-1:0] w_abs_b;

   assign w_signed   = (r_op == ALU_DIV) || (r_op == ALU_REM);
   assign w_is_rem   = (r_op == ALU_REM) || (r_op == ALU_REMU);
   assign w_valid_op = (r_op == ALU_DIV) || (r_op == ALU_DIVU) || w_is_rem;
   assign w_b_zero   = (r_b == '0);
   assign w_ovf      = w_signed && (r_a == MIN_INT) && (r_b == '1);
   assign w_abs_b    = f_abs(r_b, w_signed);

`ifdef DIV_EARLY_OUT_EN
   logic [DATA_WIDTH-1:0] w_abs_a;
   assign w_abs_a = f_abs(r_a, w_signed);
   assign w_early = (w_abs_b > w_abs_a);
`else
   assign w_early = 1'b0;
`endif

   assign w_special = !w_valid_op || w_b_zero || w_ovf || w_early;

   // results that bypass the iterative loop
   always_comb begin
      w_special_res = '0;
      if (!w_valid_op) begin
         w_special_res = '0;
      end else if (w_b_zero) begin
         w_special_res = w_is_rem ? r_a : '1;
      end else if (w_ovf) begin
         w_special_res = w_is_rem ? '0 : MIN_INT;
      end else if (w_early) begin
         w_special_res = w_is_rem ? r_a : '0;
      end
   end

   // one restoring step: shift in the next dividend bit, trial-subtract the divisor
   logic [DATA_WIDTH:0]   w_shift;
   logic [DATA_WIDTH+1:0] w_diff;
   logic                  w_neg;
   logic [DATA_WIDTH-1:0] w_rem_nxt;
   logic [DATA_WIDTH-1:0] w_q_nxt;
   logic [DATA_WIDTH-1:0] w_final;

   assign w_shift   = {r_rem, r_dvd[DATA_WIDTH-1]};
   assign w_diff    = {1'b0, w_shift} - {2'b00, w_abs_b};
   assign w_neg     = w_diff[DATA_WIDTH+1];
   assign w_rem_nxt = w_neg ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
   assign w_q_nxt   = {r_dvd[DATA_WIDTH-2:0], ~w_neg};

   // sign fixup: quotient negative on differing signs, remainder follows the dividend
   always_comb begin
      w_final = '0;
      if (w_is_rem) begin
         w_final = (w_signed && r_a[DATA_WIDTH-1]) ? -w_rem_nxt : w_rem_nxt;
      end else begin
         w_final = (w_signed && (r_a[DATA_WIDTH-1] ^ r_b[DATA_WIDTH-1])) ? -w_q_nxt : w_q_nxt;
      end
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic; kill forces IDLE from any state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = CALC;
         CALC:    if (w_special || (r_cnt == CW'(1))) w_state_nxt = DONE;
         DONE:    if (i_resp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (i_kill) begin
         w_state_nxt = IDLE;
      end
   end

   // operand latch, iteration registers and result register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_dvd    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (!i_kill) begin
         if (w_accept) begin
            r_op  <= i_req_op;
            r_a   <= i_req_a;
            r_b   <= i_req_b;
            r_dvd <= w_in_abs_a;
            r_rem <= '0;
            r_cnt <= CW'(DATA_WIDTH);
         end else if (r_state == CALC) begin
            if (w_special) begin
               r_result <= w_special_res;
            end else begin
               r_rem <= w_rem_nxt;
               r_dvd <= w_q_nxt;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_result <= w_final;
               end
            end
         end
      end
   end

   assign o_req_ready   = (r_state == IDLE);
   assign o_resp_valid  = (r_state == DONE);
   assign o_busy        = (r_state != IDLE);
   assign o_resp_result = r_result;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - directed table-driven bench for alu_div_seq
module tb_alu_div_seq;

   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_DIVU = 5'd17;
   localparam logic [4:0] OP_REM  = 5'd18;
   localparam logic [4:0] OP_REMU = 5'd19;

`ifdef DIV_EARLY_OUT_EN
   localparam int EL = 1;
`else
   localparam int EL = 32;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_kill = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [4:0]  i_req_op = '0;
   logic [31:0] i_req_a = '0;
   logic [31:0] i_req_b = '0;
   logic        o_resp_valid;
   logic        i_resp_ready = 1'b0;
   logic [31:0] o_resp_result;
   logic        o_busy;

   int errors = 0;
   int checks = 0;

   alu_div_seq #(.DATA_WIDTH(32)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_kill        (i_kill),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_op      (i_req_op),
      .i_req_a       (i_req_a),
      .i_req_b       (i_req_b),
      .o_resp_valid  (o_resp_valid),
      .i_resp_ready  (i_resp_ready),
      .o_resp_result (o_resp_result),
      .o_busy        (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int n;
      i_req_op    = v.op;
      i_req_a     = v.a;
      i_req_b     = v.b;
      i_req_valid = 1'b1;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      i_req_a     = $urandom;
      i_req_b     = $urandom;
      chk({v.name, " req_ready after accept"}, 32'(o_req_ready), 32'd0);
      n = 0;
      do begin
         @(posedge i_clk); #1;
         n++;
      end while (!o_resp_valid && n < 100);
      chk({v.name, " latency"}, 32'(n), 32'(v.lat));
      chk({v.name, " result"}, o_resp_result, v.exp);
      i_resp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_resp_ready = 1'b0;
      chk({v.name, " back to idle"}, 32'(o_req_ready), 32'd1);
   endtask

   initial begin
      int n;
      int t1;
      int t2;
      int seen;
      vecs[0]  = '{"divu 100/7",    OP_DIVU, 32'd100,        32'd7,          32'd14,         32};
      vecs[1]  = '{"remu 100/7",    OP_REMU, 32'd100,        32'd7,          32'd2,          32};
      vecs[2]  = '{"div -7/2",      OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32};
      vecs[3]  = '{"rem -7/2",      OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32};
      vecs[4]  = '{"div 5/0",       OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1};
      vecs[5]  = '{"rem 5/0",       OP_REM,  32'd5,          32'd0,          32'd5,          1};
      vecs[6]  = '{"div ovf",       OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
      vecs[7]  = '{"rem ovf",       OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
      vecs[8]  = '{"divu 3/10",     OP_DIVU, 32'd3,          32'd10,         32'd0,          EL};
      vecs[9]  = '{"remu 3/10",     OP_REMU, 32'd3,          32'd10,         32'd3,          EL};
      vecs[10] = '{"div 7/-2",      OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32};
      vecs[11] = '{"rem 7/-2",      OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          32};
      vecs[12] = '{"div -7/-2",     OP_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32};
      vecs[13] = '{"divu max/1",    OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32};
      vecs[14] = '{"remu max/16",   OP_REMU, 32'hFFFFFFFF,   32'd16,         32'd15,         32};
      vecs[15] = '{"divu max/max",  OP_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32};
      vecs[16] = '{"bad op",        5'd0,    32'd9,          32'd3,          32'd0,          1};
      vecs[17] = '{"rem -3/10",     OP_REM,  32'hFFFFFFFD,   32'd10,         32'hFFFFFFFD,   EL};

      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      chk("reset req_ready", 32'(o_req_ready), 32'd1);
      chk("reset resp_valid", 32'(o_resp_valid), 32'd0);
      chk("reset result", o_resp_result, 32'd0);
      chk("reset busy", 32'(o_busy), 32'd0);

      for (int i = 0; i < 18; i++) begin
         run_op(vecs[i]);
      end

      // backpressure: hold the response for 5 cycles
      i_req_op = OP_DIVU; i_req_a = 32'd100; i_req_b = 32'd7; i_req_valid = 1'b1;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      n = 0;
      while (!o_resp_valid && n < 100) begin
         @(posedge i_clk); #1;
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp result", o_resp_result, 32'd14);
         chk("bp req_ready", 32'(o_req_ready), 32'd0);
         chk("bp resp_valid", 32'(o_resp_valid), 32'd1);
         @(posedge i_clk); #1;
      end
      i_resp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_resp_ready = 1'b0;

      // kill after 10 CALC cycles
      i_req_op = OP_DIVU; i_req_a = 32'd1000; i_req_b = 32'd3; i_req_valid = 1'b1;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      repeat (10) @(posedge i_clk);
      #1 i_kill = 1'b1;
      @(posedge i_clk); #1;
      i_kill = 1'b0;
      chk("kill req_ready", 32'(o_req_ready), 32'd1);
      chk("kill busy", 32'(o_busy), 32'd0);
      chk("kill result kept", o_resp_result, 32'd14);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge i_clk); #1;
         if (o_resp_valid) seen++;
      end
      chk("kill no response", 32'(seen), 32'd0);

      // kill in IDLE blocks acceptance
      i_req_valid = 1'b1; i_kill = 1'b1;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0; i_kill = 1'b0;
      chk("kill idle busy", 32'(o_busy), 32'd0);

      // back-to-back throughput with resp_ready held high
      i_req_op = OP_DIVU; i_req_a = 32'd100; i_req_b = 32'd7;
      i_req_valid = 1'b1; i_resp_ready = 1'b1;
      t1 = -1; t2 = -1; n = 0;
      while (t2 < 0 && n < 200) begin
         @(posedge i_clk); #1;
         n++;
         if (o_resp_valid) begin
            if (t1 < 0) t1 = n;
            else t2 = n;
         end
      end
      i_req_valid = 1'b0;
      chk("throughput period", 32'(t2 - t1), 32'd34);
      @(posedge i_clk); #1;
      i_resp_ready = 1'b0;
      chk("throughput idle", 32'(o_busy), 32'd0);

      // reset mid-operation clears the result
      i_req_op = OP_DIVU; i_req_a = 32'd50; i_req_b = 32'd5; i_req_valid = 1'b1;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      repeat (5) @(posedge i_clk);
      #1 i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      chk("rst result", o_resp_result, 32'd0);
      chk("rst busy", 32'(o_busy), 32'd0);
      chk("rst req_ready", 32'(o_req_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
